func_y_eval: RTL and testbench
==============================

// Module: func_y_eval
// PURPOSE
//  Top-level evaluator for variant 1: y = a^2 + floor(cbrt(b)).
//  Computes a^2 internally with a shift-add squarer. Drives the external cube-root unit through its
//  start/busy handshake and consumes that unit's 8-bit root result.
//  Resource budget: the internal squarer is one of the two allowed multiplications. One shared adder
//  serves both the squarer and the final sum, so there is exactly 1 summation.
// PARAMETERS
//  W       8   operand width of a_in/b_in; y_out is 2*W bits
//  ACK_TO  4   cycles to wait for cr_busy_i to rise after a cr_start_o pulse before re-pulsing
// PORTS
//  clk        in   1    clock, all state updates on posedge
//  rst        in   1    synchronous, active-high reset
//  start      in   1    request; sampled only in IDLE
//  a_in       in   W    operand to square; latched on accepted start
//  b_in       in   W    operand for cube root; latched on accepted start
//  y_out      out  2W   result; holds last value until next DONE
//  busy_o     out  1    high from the cycle after accepted start through DONE
//  done_o     out  1    1-cycle pulse, coincident with y_out update
//  cr_start_o out  1    1-cycle start pulse to cube-root unit
//  cr_x_o     out  W    cube-root operand (latched b)
//  cr_y_i     in   W    cube-root result; valid when cr_busy_i falls
//  cr_busy_i  in   1    cube-root unit busy
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; cube-root tracker in CR_IDLE.
//  Reset also wins over any in-flight operation: no done_o pulse, and y_out is cleared.
//  Main FSM states: IDLE -> SQ -> JOIN -> ADD -> DONE -> IDLE.
//   IDLE: on start=1, latch a_in/b_in. Set acc=0, mcand={0,a}, mplier=a, cnt=0.
//         Next edge: busy_o=1, cr_x_o=b, cr_start_o=1; go to SQ.
//   SQ:   one step per cycle for exactly W cycles:
//         if mplier[0], acc<=acc+mcand; mcand<<=1; mplier>>=1.
//         After W steps go to JOIN.
//   JOIN: wait until the cr_done flag is set; then go to ADD.
//   ADD:  sum<=acc+{0,cr_res}. This is the second use of the shared adder; squaring is finished by now.
//   DONE: y_out<=sum; done_o=1 for this cycle only; busy_o<=0; cr_done<=0; go to IDLE.
//  Cube-root tracker runs concurrently with SQ. States: CR_IDLE -> CR_ACK -> CR_WAIT -> CR_IDLE.
//   CR_ACK:  cr_start_o is high exactly 1 cycle.
//            If cr_busy_i is seen high, go to CR_WAIT.
//            If it is not seen within ACK_TO cycles, re-pulse cr_start_o for 1 cycle and restart the count.
//   CR_WAIT: on cr_busy_i=0, capture cr_res<=cr_y_i, set cr_done=1, go to CR_IDLE.
//  Latency (start sample to done_o):
//   W+3 cycles if the cube-root result is captured before SQ ends.
//   Otherwise 3 cycles after cr_busy_i fall is observed.
//  Widths: acc and sum are 2W bits. Max result is (2^W-1)^2 + (2^W-1) < 2^(2W), so no overflow or wrap.
//  start while busy_o=1 is ignored; latched operands are not disturbed.
//  start held high through DONE is re-accepted in the IDLE cycle that follows (back-to-back operation).
//  cr_busy_i activity outside an operation is ignored.
//  cr_y_i is sampled only on the busy fall in CR_WAIT.
// TESTING
//  Bench uses a behavioural cube-root model with programmable ack delay and latency.
//  1. a=3,b=27 -> y_out=12; done_o exactly 1 pulse; busy_o low afterwards.
//  2. a=255,b=216 -> y_out=65031. a=0,b=0 -> y_out=0.
//     a=2,b=100 -> y_out=8, since the root is floored to 4.
//  3. Model latency 40 cycles (longer than SQ): a=5,b=1 -> y_out=26.
//     done_o arrives 3 cycles after the busy fall.
//  4. Model ignores first start pulse: cr_start_o re-pulses after ACK_TO=4 cycles.
//     Result a=4,b=8 -> 18.
//  5. start pulsed again mid-SQ with different operands: ignored; first result correct.
//     rst asserted mid-SQ: busy_o=0, y_out=0, no done_o.
//     A fresh operation after the reset completes correctly.

Source files
------------

// File: rtl/func_y_eval.sv
// Evaluates y = a^2 + floor(cbrt(b)). The square is formed with a shift-add loop, and the cube root
// comes from an external unit that runs alongside the squarer through a start/busy handshake.
module func_y_eval #(
  parameter int W      = 8,
  parameter int ACK_TO = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  output logic [2*W-1:0]   y_out,
  output logic             busy_o,
  output logic             done_o,
  output logic             cr_start_o,
  output logic [W-1:0]     cr_x_o,
  input  logic [W-1:0]     cr_y_i,
  input  logic             cr_busy_i
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SQ   = 3'd1;
  localparam logic [2:0] JOIN = 3'd2;
  localparam logic [2:0] ADD  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [1:0] CR_IDLE = 2'd0;
  localparam logic [1:0] CR_ACK  = 2'd1;
  localparam logic [1:0] CR_WAIT = 2'd2;

  localparam int CW = $clog2(W + 1);
  localparam int AW = $clog2(ACK_TO + 1);

  logic [2:0]     state;
  logic [1:0]     cr_state;
  logic [CW-1:0]  cnt;
  logic [AW-1:0]  ack_cnt;
  logic           cr_done;
  logic           accept;

  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [W-1:0]   cr_res;
  logic [2*W-1:0] add_b;
  logic [2*W-1:0] add_sum;

  assign accept = (state == IDLE) && start;

  // Single adder: partial products while squaring, then the root in ADD; acc ends up holding the sum.
  always_comb begin
    add_b   = (state == ADD) ? {{W{1'b0}}, cr_res} : mcand;
    add_sum = acc + add_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cr_state   <= CR_IDLE;
      cnt        <= '0;
      ack_cnt    <= '0;
      cr_done    <= 1'b0;
      y_out      <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      cr_start_o <= 1'b0;
      cr_x_o     <= '0;
    end else begin
      done_o     <= 1'b0;
      cr_start_o <= 1'b0;

      case (state)
        IDLE: if (start) begin
          state  <= SQ;
          cnt    <= '0;
          busy_o <= 1'b1;
          cr_x_o <= b_in;
        end
        SQ: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) state <= JOIN;
        end
        JOIN: if (cr_done) state <= ADD;
        ADD:  state <= DONE;
        DONE: begin
          y_out   <= acc;
          done_o  <= 1'b1;
          busy_o  <= 1'b0;
          cr_done <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Cube-root tracker; re-pulses start if the unit never acknowledges.
      case (cr_state)
        CR_IDLE: if (accept) begin
          cr_start_o <= 1'b1;
          ack_cnt    <= '0;
          cr_state   <= CR_ACK;
        end
        CR_ACK: begin
          if (cr_busy_i) begin
            cr_state <= CR_WAIT;
          end else if (ack_cnt == AW'(ACK_TO - 1)) begin
            cr_start_o <= 1'b1;
            ack_cnt    <= '0;
          end else begin
            ack_cnt <= ack_cnt + AW'(1);
          end
        end
        CR_WAIT: if (!cr_busy_i) begin
          cr_done  <= 1'b1;
          cr_state <= CR_IDLE;
        end
        default: cr_state <= CR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      acc    <= '0;
      mcand  <= {{W{1'b0}}, a_in};
      mplier <= a_in;
    end else if (state == SQ) begin
      if (mplier[0]) acc <= add_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end else if (state == ADD) begin
      acc <= add_sum;
    end
    if (cr_state == CR_WAIT && !cr_busy_i) cr_res <= cr_y_i;
  end

endmodule

// File: tb/tb_func_y_eval.sv
// Directed bench for func_y_eval with a behavioural cube-root unit (programmable ack delay, latency
// and ignored-start count) and a result model that tracks y_out every cycle.
module tb_func_y_eval;
  localparam int W      = 8;
  localparam int ACK_TO = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   a_in = '0;
  logic [W-1:0]   b_in = '0;
  logic [2*W-1:0] y_out;
  logic           busy_o, done_o, cr_start_o;
  logic [W-1:0]   cr_x_o;
  logic [W-1:0]   cr_y_i = '0;
  logic           cr_busy_i = 1'b0;

  always #5 clk = ~clk;

  func_y_eval #(.W(W), .ACK_TO(ACK_TO)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .y_out(y_out), .busy_o(busy_o), .done_o(done_o), .cr_start_o(cr_start_o),
    .cr_x_o(cr_x_o), .cr_y_i(cr_y_i), .cr_busy_i(cr_busy_i)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int icbrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic int model_y(input int a, input int b);
    return a * a + icbrt(b);
  endfunction

  // Behavioural cube-root unit
  int         ack_dly = 0;
  int         lat = 3;
  int         ignore_n = 0;
  logic       m_pending = 1'b0;
  logic       m_active = 1'b0;
  int         m_ack_left = 0;
  int         m_lat_left = 0;
  logic [W-1:0] m_x = '0;

  always @(posedge clk) begin
    if (m_pending) begin
      if (m_ack_left == 0) begin
        cr_busy_i  <= 1'b1;
        m_lat_left <= lat;
        m_pending  <= 1'b0;
        m_active   <= 1'b1;
      end else begin
        m_ack_left <= m_ack_left - 1;
      end
    end else if (m_active) begin
      if (m_lat_left <= 1) begin
        cr_busy_i <= 1'b0;
        cr_y_i    <= W'(icbrt(int'(m_x)));
        m_active  <= 1'b0;
      end else begin
        m_lat_left <= m_lat_left - 1;
      end
    end else if (cr_start_o) begin
      if (ignore_n > 0) begin
        ignore_n <= ignore_n - 1;
      end else begin
        m_x        <= cr_x_o;
        m_pending  <= 1'b1;
        m_ack_left <= ack_dly;
      end
    end
  end

  // Result model and per-cycle compare
  int   exp_q[$];
  int   y_hold = 0;
  int   cur_b = 0;
  bit   chk_en = 0;
  int   rise_cyc[$];
  int   fall_cyc = 0;
  int   done_cyc = 0;
  logic cs_prev = 1'b0, bz_prev = 1'b0, dn_prev = 1'b0;

  always @(negedge clk) begin
    if (cr_start_o && !cs_prev) rise_cyc.push_back(cyc);
    if (bz_prev && !cr_busy_i) fall_cyc = cyc;
    if (done_o && !dn_prev) done_cyc = cyc;
    cs_prev = cr_start_o;
    bz_prev = cr_busy_i;
    dn_prev = done_o;
    if (chk_en) begin
      if (done_o) begin
        if (exp_q.size() == 0) check("unexpected_done", {31'd0, done_o}, 32'd0);
        else y_hold = exp_q.pop_front();
      end
      check("y_out_track", {16'd0, y_out}, y_hold);
      if (cr_start_o) check("cr_x_o", {24'd0, cr_x_o}, cur_b);
    end
  end

  task automatic run_op(input int a, input int b, input int exp_lit, input bit chk_lat,
                        input bit intrude);
    int  t0;
    bit  got;
    bit  idle;
    check("model_pin", model_y(a, b), exp_lit);
    idle = 0;
    for (int i = 0; i < 200 && !idle; i++) begin
      if (!busy_o) idle = 1;
      else @(negedge clk);
    end
    check("idle_before_start", {31'd0, idle}, 32'd1);
    a_in = W'(a); b_in = W'(b); start = 1'b1; cur_b = b;
    exp_q.push_back(exp_lit);
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      start = intrude && (i == 3);
      if (start) begin a_in = 8'd9; b_in = 8'd9; end
      if (done_o) got = 1;
      else @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", {31'd0, got}, 32'd1);
    if (got) begin
      check("y_out", {16'd0, y_out}, exp_lit);
      check("busy_at_done", {31'd0, busy_o}, 32'd0);
      if (chk_lat) check("latency", cyc - t0 - 1, W + 3);
      @(negedge clk);
      check("done_one_cycle", {31'd0, done_o}, 32'd0);
      @(negedge clk);
      check("busy_stays_low", {31'd0, busy_o}, 32'd0);
    end
  endtask

  task automatic wait_model_idle();
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (!m_pending && !m_active && !cr_busy_i) ok = 1;
      else @(negedge clk);
    end
    check("model_idle", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    bit saw_done;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_y_out", {16'd0, y_out}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_cr_start", {31'd0, cr_start_o}, 32'd0);
    check("rst_cr_x", {24'd0, cr_x_o}, 32'd0);
    chk_en = 1;

    run_op(3, 27, 12, 1, 0);
    run_op(255, 216, 65031, 1, 0);
    run_op(0, 0, 0, 1, 0);
    run_op(2, 100, 8, 1, 0);

    // Root arrives long after squaring: done follows the observed fall by 3 edges
    lat = 40;
    run_op(5, 1, 26, 0, 0);
    check("late_done_after_fall", done_cyc - fall_cyc, 1 + 3);
    lat = 3;

    // First start pulse is dropped by the unit, so the tracker must re-pulse
    wait_model_idle();
    ignore_n = 1;
    rise_cyc.delete();
    run_op(4, 8, 18, 0, 0);
    check("repulse_count", rise_cyc.size(), 2);
    if (rise_cyc.size() >= 2) check("repulse_gap", rise_cyc[1] - rise_cyc[0], ACK_TO);
    ignore_n = 0;

    wait_model_idle();
    run_op(11, 30, 124, 1, 1);

    // Reset in the middle of squaring
    wait_model_idle();
    a_in = 8'd7; b_in = 8'd64; cur_b = 64; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_y_out", {16'd0, y_out}, 32'd0);
    check("midrst_done", {31'd0, done_o}, 32'd0);
    exp_q.delete();
    y_hold = 0;
    chk_en = 1;
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) saw_done = 1;
      @(negedge clk);
    end
    check("no_done_after_rst", {31'd0, saw_done}, 32'd0);
    wait_model_idle();
    run_op(6, 125, 41, 1, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
